// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file defaults and read-request type
package rf_pkg;

  localparam int RF_WIDTH     = 64;
  localparam int RF_LG_DEPTH  = 5;
  localparam int RF_TAG_WIDTH = 8;

  // Read request as produced by issue/rename and consumed by the read pipe.
  typedef struct packed {
    logic [RF_LG_DEPTH-1:0]  raddr0;
    logic [RF_LG_DEPTH-1:0]  raddr1;
    logic [RF_TAG_WIDTH-1:0] tag;
  } rf_req_t;

endpackage

// File: rtl/ram2r1w.sv
// rtl/ram2r1w.sv - two-read one-write register RAM with registered reads
module ram2r1w #(
  parameter int WIDTH    = 64,
  parameter int LG_DEPTH = 5
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [LG_DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [LG_DEPTH-1:0] rd_addr0,
  input  logic [LG_DEPTH-1:0] rd_addr1,
  output logic [WIDTH-1:0]    rd_data0,
  output logic [WIDTH-1:0]    rd_data1
);

  logic [WIDTH-1:0] mem [0:(1<<LG_DEPTH)-1];

  // Storage is not reset; a same-cycle read of a written address sees the old value.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data0 <= mem[rd_addr0];
    rd_data1 <= mem[rd_addr1];
  end

endmodule

// File: rtl/rf_fwd_port.sv
// rtl/rf_fwd_port.sv - per-operand write forwarding, zero-register masking and output register
module rf_fwd_port
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int LG_DEPTH = RF_LG_DEPTH,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LG_DEPTH-1:0] rd_addr,
  input  logic                wr_eff,
  input  logic [LG_DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [WIDTH-1:0]    ram_data,
  input  logic [LG_DEPTH-1:0] s1_addr,
  input  logic                s1_adv,
  input  logic                s2_hold,
  output logic [WIDTH-1:0]    out_rdata
);

  logic                fwd_valid;
  logic [WIDTH-1:0]    fwd_data;
  logic [LG_DEPTH-1:0] s2_addr;
  logic                s1_zero;
  logic [WIDTH-1:0]    s1_data;
  logic [WIDTH-1:0]    s1_load;

  // The RAM returns pre-write data, so a write colliding with the read address is
  // captured here and substituted one cycle later.
  assign s1_zero = (ZERO_REG != 0) && (s1_addr == '0);
  assign s1_data = s1_zero ? '0 : (fwd_valid ? fwd_data : ram_data);
  assign s1_load = s1_zero ? '0 :
                   ((wr_eff && (wr_addr == s1_addr)) ? wr_data : s1_data);

  // Capture a write that hits the address being read this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= wr_eff && (wr_addr == rd_addr);
      fwd_data  <= wr_data;
    end
  end

  // Output operand: load from S1, or track writes to its address while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_rdata <= '0;
      s2_addr   <= '0;
    end else if (s1_adv) begin
      out_rdata <= s1_load;
      s2_addr   <= s1_addr;
    end else if (s2_hold && wr_eff && (wr_addr == s2_addr)) begin
      out_rdata <= wr_data;
    end
  end

endmodule

// File: rtl/regfile_read_pipe.sv
// rtl/regfile_read_pipe.sv - two-stage valid/ready register-file read pipeline with forwarding
module regfile_read_pipe
  import rf_pkg::*;
#(
  parameter int WIDTH     = RF_WIDTH,
  parameter int LG_DEPTH  = RF_LG_DEPTH,
  parameter int TAG_WIDTH = RF_TAG_WIDTH,
  parameter int ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LG_DEPTH-1:0]  in_raddr0,
  input  logic [LG_DEPTH-1:0]  in_raddr1,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 wr_en,
  input  logic [LG_DEPTH-1:0]  wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_rdata0,
  output logic [WIDTH-1:0]     out_rdata1,
  output logic [TAG_WIDTH-1:0] out_tag
);

  logic                 s1_valid;
  logic [LG_DEPTH-1:0]  s1_addr0;
  logic [LG_DEPTH-1:0]  s1_addr1;
  logic [TAG_WIDTH-1:0] s1_tag;

  logic                 s2_en;
  logic                 s1_adv;
  logic                 s1_hold;
  logic                 s2_hold;
  logic                 accept;
  logic                 wr_eff;
  logic [LG_DEPTH-1:0]  ra0;
  logic [LG_DEPTH-1:0]  ra1;
  logic [WIDTH-1:0]     ram_d0;
  logic [WIDTH-1:0]     ram_d1;

  assign s2_en    = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_en;
  assign s1_hold  = s1_valid && !s2_en;
  assign s2_hold  = out_valid && !out_ready;
  assign in_ready = !reset && !flush && (!s1_valid || s2_en);
  assign accept   = in_valid && in_ready;

  // Writes to the hard-wired zero register never reach the RAM or any forward compare.
  assign wr_eff = wr_en && !reset && !((ZERO_REG != 0) && (wr_addr == '0));

  // A stalled S1 keeps re-reading its own address so the RAM data stays current.
  assign ra0 = s1_hold ? s1_addr0 : in_raddr0;
  assign ra1 = s1_hold ? s1_addr1 : in_raddr1;

  ram2r1w #(
    .WIDTH   (WIDTH),
    .LG_DEPTH(LG_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_eff),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr0(ra0),
    .rd_addr1(ra1),
    .rd_data0(ram_d0),
    .rd_data1(ram_d1)
  );

  rf_fwd_port #(
    .WIDTH   (WIDTH),
    .LG_DEPTH(LG_DEPTH),
    .ZERO_REG(ZERO_REG)
  ) u_port0 (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (ra0),
    .wr_eff   (wr_eff),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ram_data (ram_d0),
    .s1_addr  (s1_addr0),
    .s1_adv   (s1_adv),
    .s2_hold  (s2_hold),
    .out_rdata(out_rdata0)
  );

  rf_fwd_port #(
    .WIDTH   (WIDTH),
    .LG_DEPTH(LG_DEPTH),
    .ZERO_REG(ZERO_REG)
  ) u_port1 (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (ra1),
    .wr_eff   (wr_eff),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ram_data (ram_d1),
    .s1_addr  (s1_addr1),
    .s1_adv   (s1_adv),
    .s2_hold  (s2_hold),
    .out_rdata(out_rdata1)
  );

  // S1 request register: filled on accept, emptied on advance, dropped on flush/reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_addr0 <= '0;
      s1_addr1 <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_addr0 <= in_raddr0;
      s1_addr1 <= in_raddr1;
      s1_tag   <= in_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 control and tag: drain and refill in the same cycle without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_adv) out_tag <= s1_tag;
    end
  end

endmodule
